// File: rtl/match_motion_accum_if.sv
// Bus between the matching stage, the motion accumulator and the pose/control consumer.
// Result handshake: a transfer happens on a rising edge where o_result_valid && i_ready;
// once raised, o_result_valid and all result fields stay stable until that transfer.
interface match_motion_accum_if;
  logic              i_frame_start;
  logic              i_frame_end;
  logic              i_valid;
  logic [9:0]        i_src_coor_x;
  logic [9:0]        i_src_coor_y;
  logic [9:0]        i_dst_coor_x;
  logic [9:0]        i_dst_coor_y;
  logic              i_ready;
  logic              o_result_valid;
  logic signed [10:0] o_mean_dx;
  logic signed [10:0] o_mean_dy;
  logic [9:0]        o_count;
  logic [9:0]        o_reject;
  logic              o_overflow;
  logic              o_overrun;
  logic              o_busy;

  modport master (
    output i_frame_start, i_frame_end, i_valid,
    output i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y, i_ready,
    input  o_result_valid, o_mean_dx, o_mean_dy, o_count, o_reject,
    input  o_overflow, o_overrun, o_busy
  );

  modport slave (
    input  i_frame_start, i_frame_end, i_valid,
    input  i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y, i_ready,
    output o_result_valid, o_mean_dx, o_mean_dy, o_count, o_reject,
    output o_overflow, o_overrun, o_busy
  );
endinterface

// File: rtl/match_motion_accum.sv
// Per-frame mean translation of matched keypoint pairs: outlier gate, per-axis sums,
// then a 21-step restoring divider shared by both axes in parallel.
module match_motion_accum #(
  parameter logic [9:0] MAX_PAIRS = 10'd500,
  parameter logic [9:0] MAX_DISP  = 10'd64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  match_motion_accum_if.slave   bus,
  output logic [1:0]            o_dbg_state
);
  localparam logic [4:0] DIV_LAST = 5'd20;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DIV = 2'd2, S_OUT = 2'd3} state_t;
  state_t state, state_next;

  logic [10:0] dx, dy, abs_dx, abs_dy;
  logic        outlier, take_pair, clear;
  logic [20:0] sum_dx, sum_dy, base_dx, base_dy, abs_sum_dx, abs_sum_dy;
  logic [9:0]  count, base_count, rej, base_rej;
  logic        ovf, base_ovf;
  logic [4:0]  div_cnt;
  logic [9:0]  r_x, r_y;
  logic [20:0] q_x, q_y;
  logic [30:0] step_x, step_y;
  logic [10:0] res_dx, res_dy;
  logic signed [10:0] mean_dx, mean_dy;
  logic [9:0]  res_count, res_reject;
  logic        res_overflow, overrun;

  assign dx      = {1'b0, bus.i_dst_coor_x} - {1'b0, bus.i_src_coor_x};
  assign dy      = {1'b0, bus.i_dst_coor_y} - {1'b0, bus.i_src_coor_y};
  assign abs_dx  = dx[10] ? (~dx + 11'd1) : dx;
  assign abs_dy  = dy[10] ? (~dy + 11'd1) : dy;
  assign outlier = (abs_dx > {1'b0, MAX_DISP}) || (abs_dy > {1'b0, MAX_DISP});

  // A frame_start seen in IDLE or ACCUM opens a fresh frame; a same-cycle pair lands in it.
  assign clear     = bus.i_frame_start && ((state == S_IDLE) || (state == S_ACCUM));
  assign take_pair = bus.i_valid && ((state == S_ACCUM) || ((state == S_IDLE) && bus.i_frame_start));

  always_comb begin
    base_dx    = clear ? '0 : sum_dx;
    base_dy    = clear ? '0 : sum_dy;
    base_count = clear ? '0 : count;
    base_rej   = clear ? '0 : rej;
    base_ovf   = clear ? 1'b0 : ovf;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_dx <= '0;
      sum_dy <= '0;
      count  <= '0;
      rej    <= '0;
      ovf    <= 1'b0;
    end else begin
      sum_dx <= base_dx;
      sum_dy <= base_dy;
      count  <= base_count;
      rej    <= base_rej;
      ovf    <= base_ovf;
      if (take_pair) begin
        if (outlier) begin
          if (base_rej != 10'h3ff) rej <= base_rej + 10'd1;
        end else if (base_count < MAX_PAIRS) begin
          sum_dx <= base_dx + {{10{dx[10]}}, dx};
          sum_dy <= base_dy + {{10{dy[10]}}, dy};
          count  <= base_count + 10'd1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [30:0] div_step(input logic [9:0] r, input logic [20:0] q,
                                           input logic [9:0] d);
    logic [10:0] r_sh;
    logic [9:0]  r_new;
    logic [20:0] q_sh;
    r_sh = {r, q[20]};
    q_sh = {q[19:0], 1'b0};
    if (r_sh >= {1'b0, d}) begin
      r_new   = 10'(r_sh - {1'b0, d});
      q_sh[0] = 1'b1;
    end else begin
      r_new = r_sh[9:0];
    end
    return {r_new, q_sh};
  endfunction

  assign abs_sum_dx = sum_dx[20] ? (~sum_dx + 21'd1) : sum_dx;
  assign abs_sum_dy = sum_dy[20] ? (~sum_dy + 21'd1) : sum_dy;

  always_comb begin
    step_x = div_step((div_cnt == 5'd0) ? 10'd0 : r_x, (div_cnt == 5'd0) ? abs_sum_dx : q_x, count);
    step_y = div_step((div_cnt == 5'd0) ? 10'd0 : r_y, (div_cnt == 5'd0) ? abs_sum_dy : q_y, count);
    res_dx = sum_dx[20] ? (~step_x[10:0] + 11'd1) : step_x[10:0];
    res_dy = sum_dy[20] ? (~step_y[10:0] + 11'd1) : step_y[10:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_cnt <= '0;
      r_x     <= '0;
      r_y     <= '0;
      q_x     <= '0;
      q_y     <= '0;
    end else if (state == S_DIV) begin
      div_cnt    <= div_cnt + 5'd1;
      {r_x, q_x} <= step_x;
      {r_y, q_y} <= step_y;
    end else begin
      div_cnt <= '0;
    end
  end

  // Results are snapshotted on the last divide step and then held until the next frame's.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mean_dx      <= '0;
      mean_dy      <= '0;
      res_count    <= '0;
      res_reject   <= '0;
      res_overflow <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (bus.i_frame_start && ((state == S_DIV) || (state == S_OUT))) overrun <= 1'b1;
      if ((state == S_DIV) && (div_cnt == DIV_LAST)) begin
        mean_dx      <= (count == 10'd0) ? 11'sd0 : $signed(res_dx);
        mean_dy      <= (count == 10'd0) ? 11'sd0 : $signed(res_dy);
        res_count    <= count;
        res_reject   <= rej;
        res_overflow <= ovf;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.i_frame_start) state_next = bus.i_frame_end ? S_DIV : S_ACCUM;
      S_ACCUM: if (bus.i_frame_end) state_next = S_DIV;
      S_DIV:   if (div_cnt == DIV_LAST) state_next = S_OUT;
      S_OUT:   if (bus.i_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.o_result_valid = (state == S_OUT);
  assign bus.o_busy         = (state == S_DIV) || (state == S_OUT);
  assign bus.o_mean_dx      = mean_dx;
  assign bus.o_mean_dy      = mean_dy;
  assign bus.o_count        = res_count;
  assign bus.o_reject       = res_reject;
  assign bus.o_overflow     = res_overflow;
  assign bus.o_overrun      = overrun;
  assign o_dbg_state        = state;
endmodule

// File: tb/tb_match_motion_accum.sv
// Directed bench for match_motion_accum: a frame-level model (lists of accepted displacements,
// integer mean) is compared against the DUT every cycle, plus hand-computed literal results.
module tb_match_motion_accum;
  localparam int TB_MAX_PAIRS = 4;
  localparam int TB_MAX_DISP  = 64;
  localparam int DIV_CYCLES   = 21;
  localparam int M_IDLE = 0, M_ACCUM = 1, M_BUSY = 2, M_OUT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  match_motion_accum_if mif();
  logic [1:0] dbg_state;

  match_motion_accum #(
    .MAX_PAIRS(10'(TB_MAX_PAIRS)),
    .MAX_DISP (10'(TB_MAX_DISP))
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (mif),
    .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  int acc_dx[$];
  int acc_dy[$];
  logic [42:0] exp_q[$];   // {mean_dx, mean_dy, count, reject, overflow}
  int m_mode, m_left, m_rej;
  bit m_ovf, m_overrun;
  int e_mdx, e_mdy, e_cnt, e_rej;
  bit e_ovf;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_open();
    acc_dx.delete();
    acc_dy.delete();
    m_rej = 0;
    m_ovf = 1'b0;
  endtask

  task automatic m_take();
    int dx, dy;
    dx = int'(mif.i_dst_coor_x) - int'(mif.i_src_coor_x);
    dy = int'(mif.i_dst_coor_y) - int'(mif.i_src_coor_y);
    if (iabs(dx) > TB_MAX_DISP || iabs(dy) > TB_MAX_DISP) begin
      if (m_rej < 1023) m_rej++;
    end else if (acc_dx.size() < TB_MAX_PAIRS) begin
      acc_dx.push_back(dx);
      acc_dy.push_back(dy);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic m_close();
    int n, sx, sy, mx, my;
    n = acc_dx.size();
    sx = 0;
    sy = 0;
    foreach (acc_dx[i]) begin
      sx += acc_dx[i];
      sy += acc_dy[i];
    end
    mx = (n == 0) ? 0 : sx / n;   // integer division truncates toward zero
    my = (n == 0) ? 0 : sy / n;
    exp_q.push_back({11'(mx), 11'(my), 10'(n), 10'(m_rej), m_ovf});
    m_left = DIV_CYCLES;
    m_mode = M_BUSY;
  endtask

  task automatic m_publish();
    logic [42:0] v;
    v = exp_q.pop_front();
    e_mdx = int'($signed(v[42:32]));
    e_mdy = int'($signed(v[31:21]));
    e_cnt = int'(v[20:11]);
    e_rej = int'(v[10:1]);
    e_ovf = v[0];
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_left = 0;
      m_overrun = 1'b0;
      m_open();
      exp_q.delete();
      e_mdx = 0; e_mdy = 0; e_cnt = 0; e_rej = 0; e_ovf = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_ACCUM: begin
          if (mif.i_frame_start) m_open();
          if (m_mode == M_ACCUM || mif.i_frame_start) begin
            if (mif.i_valid) m_take();
            if (mif.i_frame_end) m_close();
            else m_mode = M_ACCUM;
          end
        end
        M_BUSY: begin
          if (mif.i_frame_start) m_overrun = 1'b1;
          m_left--;
          if (m_left == 0) begin
            m_mode = M_OUT;
            m_publish();
          end
        end
        default: begin
          if (mif.i_frame_start) m_overrun = 1'b1;
          if (mif.i_ready) m_mode = M_IDLE;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid",    int'(mif.o_result_valid), int'(m_mode == M_OUT));
      check("cyc_busy",     int'(mif.o_busy), int'(m_mode == M_BUSY || m_mode == M_OUT));
      check("cyc_overrun",  int'(mif.o_overrun), int'(m_overrun));
      check("cyc_mean_dx",  int'($signed(mif.o_mean_dx)), e_mdx);
      check("cyc_mean_dy",  int'($signed(mif.o_mean_dy)), e_mdy);
      check("cyc_count",    int'(mif.o_count), e_cnt);
      check("cyc_reject",   int'(mif.o_reject), e_rej);
      check("cyc_overflow", int'(mif.o_overflow), int'(e_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input int sx, input int sy, input int dx, input int dy);
    mif.i_valid      = 1'b1;
    mif.i_src_coor_x = 10'(sx);
    mif.i_src_coor_y = 10'(sy);
    mif.i_dst_coor_x = 10'(dx);
    mif.i_dst_coor_y = 10'(dy);
    tick();
    mif.i_valid = 1'b0;
  endtask

  task automatic start_frame();
    mif.i_frame_start = 1'b1;
    tick();
    mif.i_frame_start = 1'b0;
  endtask

  task automatic end_frame();
    mif.i_frame_end = 1'b1;
    tick();
    mif.i_frame_end = 1'b0;
  endtask

  // Edges after the frame_end edge until OUT; frame_end in cycle T gives OUT in cycle T+22,
  // which begins 21 edges after the sampling edge.
  task automatic wait_result(input string name);
    int lat;
    lat = 0;
    while (!mif.o_result_valid && lat < 60) begin
      tick();
      lat++;
    end
    check(name, lat, DIV_CYCLES);
  endtask

  task automatic expect_result(input string tag, input int mdx, input int mdy,
                               input int cnt, input int rej, input int ovf);
    check({tag, "_mean_dx"},  int'($signed(mif.o_mean_dx)), mdx);
    check({tag, "_mean_dy"},  int'($signed(mif.o_mean_dy)), mdy);
    check({tag, "_count"},    int'(mif.o_count), cnt);
    check({tag, "_reject"},   int'(mif.o_reject), rej);
    check({tag, "_overflow"}, int'(mif.o_overflow), ovf);
  endtask

  task automatic handshake();
    mif.i_ready = 1'b1;
    tick();
    mif.i_ready = 1'b0;
    check("post_handshake_valid", int'(mif.o_result_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    mif.i_frame_start = 1'b0;
    mif.i_frame_end   = 1'b0;
    mif.i_valid       = 1'b0;
    mif.i_src_coor_x  = '0;
    mif.i_src_coor_y  = '0;
    mif.i_dst_coor_x  = '0;
    mif.i_dst_coor_y  = '0;
    mif.i_ready       = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid", int'(mif.o_result_valid), 0);
    check("reset_busy", int'(mif.o_busy), 0);
    expect_result("reset", 0, 0, 0, 0, 0);

    // Basic mean: dx 4,6,5 dy -2,-4,3 -> 5, -1
    start_frame();
    pair(100, 100, 104, 98);
    pair(200, 50, 206, 46);
    pair(10, 10, 15, 13);
    end_frame();
    wait_result("basic_latency");
    expect_result("basic", 5, -1, 3, 0, 0);
    handshake();

    // Negative truncation toward zero: -15/2 -> -7
    start_frame();
    pair(20, 20, 13, 20);
    pair(20, 20, 12, 20);
    end_frame();
    wait_result("neg_latency");
    expect_result("neg", -7, 0, 2, 0, 0);
    handshake();

    // Outlier gate: 65 rejected, +64 and -64 accepted
    start_frame();
    pair(0, 0, 65, 0);
    pair(100, 5, 164, 5);
    pair(100, 5, 36, 5);
    end_frame();
    wait_result("gate_latency");
    expect_result("gate", 0, 0, 2, 1, 0);
    handshake();

    // Restart mid-frame discards the partial frame
    start_frame();
    pair(0, 0, 20, 0);
    start_frame();
    pair(0, 0, 2, 0);
    end_frame();
    wait_result("restart_latency");
    expect_result("restart", 2, 0, 1, 0, 0);
    handshake();

    // Empty frame with ready held high; the frame_start at T+23 opens the overflow frame
    mif.i_ready = 1'b1;
    mif.i_frame_start = 1'b1;
    mif.i_frame_end = 1'b1;
    tick();
    mif.i_frame_start = 1'b0;
    mif.i_frame_end = 1'b0;
    wait_result("empty_latency");
    expect_result("empty", 0, 0, 0, 0, 0);
    tick();
    check("empty_auto_ack_valid", int'(mif.o_result_valid), 0);
    mif.i_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 6; i++) pair(10 * i, 7, 10 * i + 1, 7);
    end_frame();
    wait_result("ovf_latency");
    expect_result("ovf", 1, 0, 4, 0, 1);
    handshake();

    // Backpressure, then a frame_start while busy
    start_frame();
    pair(10, 10, 13, 12);
    end_frame();
    wait_result("bp_latency");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", int'(mif.o_result_valid), 1);
      check("bp_hold_mean_dx", int'($signed(mif.o_mean_dx)), 3);
    end
    start_frame();
    pair(0, 0, 9, 9);
    end_frame();
    check("overrun_set", int'(mif.o_overrun), 1);
    expect_result("bp", 3, 2, 1, 0, 0);
    handshake();
    pair(0, 0, 9, 9);
    end_frame();
    for (int i = 0; i < 25; i++) tick();
    check("idle_no_result", int'(mif.o_result_valid), 0);
    start_frame();
    pair(20, 30, 18, 30);
    end_frame();
    wait_result("rearm_latency");
    expect_result("rearm", -2, 0, 1, 0, 0);
    handshake();

    // Reset in the middle of the divide
    start_frame();
    pair(0, 0, 30, 30);
    end_frame();
    for (int i = 0; i < 8; i++) tick();
    check("middiv_busy", int'(mif.o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", int'(mif.o_busy), 0);
    check("rst_valid", int'(mif.o_result_valid), 0);
    check("rst_overrun", int'(mif.o_overrun), 0);
    expect_result("rst", 0, 0, 0, 0, 0);

    // Frame after reset: dx 10,-3 dy -10,3 -> 3, -3
    start_frame();
    pair(500, 500, 510, 490);
    pair(300, 300, 297, 303);
    end_frame();
    wait_result("post_rst_latency");
    expect_result("post_rst", 3, -3, 2, 0, 0);
    handshake();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
